mem_bus_responder: RTL and testbench
====================================

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, meaning number of 32-bit words stored.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response (range 0..15).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h1001_0000, meaning byte address of word 0.
REQ-004 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  input  1  requester presents an access.
REQ-007 Port: req_we  input  1  1 = write, 0 = read.
REQ-008 Port: req_addr  input  32  byte address.
REQ-009 Port: req_wdata  input  32  write data.
REQ-010 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-011 Port: rsp_valid  output  1  one-cycle pulse; access complete.
REQ-012 Port: rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-013 Port: rsp_err  output  1  access rejected, valid with rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, req_valid=1 SHALL be accepted at the clock edge; addr, we and wdata are captured at that edge; next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-016 WAIT SHALL count down from WAIT_CYCLES-1 and move to RESP on the edge where the count is 0; total WAIT residency is exactly WAIT_CYCLES cycles.
REQ-017 rsp_valid SHALL be high for exactly one cycle (RESP), WAIT_CYCLES+1 cycles after the accepting edge; RESP always returns to IDLE with no backpressure.
REQ-018 Word index = (addr - BASE_ADDR) >> 2; the address is out of range when addr < BASE_ADDR or index >= MEM_DEPTH.
REQ-019 An in-range write SHALL update the array on the edge entering RESP; rsp_rdata SHALL be 0 for writes.
REQ-020 An in-range read SHALL register array[index] into rsp_rdata on the edge entering RESP.
REQ-021 An out-of-range access SHALL not modify the array, and SHALL return rsp_rdata=0 and rsp_err=1.
REQ-022 rsp_rdata and rsp_err SHALL hold their last values outside RESP; rsp_err SHALL be 0 for in-range accesses.
REQ-023 req_valid in WAIT or RESP SHALL be ignored; a held request is accepted in the following IDLE cycle, so back-to-back accesses are spaced WAIT_CYCLES+2 cycles apart.
REQ-024 A read following a write to the same index SHALL return the newly written data.

Reset
REQ-025 rst=1 SHALL force, asynchronously: state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1.
REQ-026 Reset asserted in WAIT SHALL abort the access: no array write and no rsp_valid.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MISALIGN_CHECK_EN SHALL select alignment checking.
REQ-029 With MISALIGN_CHECK_EN defined, req_addr[1:0] != 0 SHALL be treated as out of range per REQ-021.
REQ-030 Without MISALIGN_CHECK_EN, req_addr[1:0] SHALL be ignored and the access treated as word-aligned.

Verification
REQ-031 Reset, then write 0xDEADBEEF to 0x1001_0004 -> rsp_valid exactly 3 cycles after acceptance, rsp_err=0; a later read of 0x1001_0004 returns 0xDEADBEEF.
REQ-032 Read 0x1001_0400 (index 256) -> rsp_err=1, rsp_rdata=0; a following read of index 0 shows unchanged contents.
REQ-033 req_valid held continuously with 3 reads -> req_ready pulses every 4 cycles; 3 rsp_valid pulses, each one cycle wide.
REQ-034 rst pulsed during WAIT of a write of 0x12345678 to 0x1001_0008 -> no rsp_valid, req_ready=1; a later read of 0x1001_0008 returns the old value.
REQ-035 Write to 0x1001_0006 -> with MISALIGN_CHECK_EN: rsp_err=1 and no write; without it: data lands at index 1.
REQ-036 WAIT_CYCLES=0 -> rsp_valid on the cycle after acceptance.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Single-port word memory behind a valid/ready request bus with a fixed wait-state count.
// Optional alignment checking is enabled by defining MISALIGN_CHECK_EN.
module mem_bus_responder #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and req_ready
  // are both 1; rsp_valid is a single-cycle pulse with no backpressure.

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [MEM_DEPTH];

  logic [31:0]      acc_addr, acc_wdata, word_off;
  logic             acc_we, in_range, accept, enter_resp;
  logic [IDX_W-1:0] idx;

  // With zero wait states the access happens on the accepting edge, so the
  // live request is used while idle and the captured copy otherwise.
  always_comb begin
    accept    = (state_q == ST_IDLE) && req_valid;
    acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    word_off  = (acc_addr - BASE_ADDR) >> 2;
    in_range  = (acc_addr >= BASE_ADDR) && (word_off < MEM_DEPTH);
`ifdef MISALIGN_CHECK_EN
    in_range  = in_range && (acc_addr[1:0] == 2'b00);
`endif
    idx       = word_off[IDX_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (enter_resp) begin
      err_d   = !in_range;
      rdata_d = (!acc_we && in_range) ? mem_q[idx] : 32'd0;
    end
  end

  // Array is deliberately outside the reset domain; an aborted access never
  // reaches enter_resp because reset has already returned the FSM to idle.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_we && in_range) mem_q[idx] <= acc_wdata;
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: default instance (2 wait states) plus a zero-wait instance.
module tb_mem_bus_responder;

  localparam int          WAITC = 2;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        r0_valid, r0_we;
  logic [31:0] r0_addr, r0_wdata;
  logic        r0_ready, r0_rsp_valid, r0_rsp_err;
  logic [31:0] r0_rsp_rdata;
  logic [1:0]  r0_dbg_state;

  always #5 clk = ~clk;

  mem_bus_responder #(.MEM_DEPTH(256), .WAIT_CYCLES(WAITC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  mem_bus_responder #(.MEM_DEPTH(256), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
    .clk(clk), .rst(rst), .req_valid(r0_valid), .req_we(r0_we),
    .req_addr(r0_addr), .req_wdata(r0_wdata), .req_ready(r0_ready),
    .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err),
    .dbg_state(r0_dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [32:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] model_mem [256];
  logic [31:0] last_rdata = 32'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon_blk
    logic [32:0] e;
    int c;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check_val("rsp_rdata", rsp_rdata, e[31:0]);
        check_val("rsp_err", rsp_err, e[32]);
        check_val("rsp_cycle", cyc, c);
        last_rdata = e[31:0];
      end
    end
  end

  // Called and returns on a falling edge; acc is the cycle count before the accepting edge.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input bit keep, input bit abort, output int acc);
    int guard = 0;
    logic [31:0] off;
    logic inr;
    int idx;
    while (req_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check_val("ready_timeout", 64'd0, 64'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    acc       = cyc;
    off = (addr - BASE) >> 2;
    inr = (addr >= BASE) && (off < 32'd256);
`ifdef MISALIGN_CHECK_EN
    inr = inr && (addr[1:0] == 2'b00);
`endif
    idx = int'(off[7:0]);
    if (!abort) begin
      exp_q.push_back({!inr, (we || !inr) ? 32'h0 : model_mem[idx]});
      exp_cyc_q.push_back(cyc + WAITC + 1);
      if (we && inr) model_mem[idx] = wd;
    end
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", exp_q.size(), 64'd0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    logic we;
    int sel;
    logic [31:0] addr;
    bit keep;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 32'd0; r0_wdata = 32'd0;
    #1;
    check_val("rst_ready", req_ready, 1);
    check_val("rst_valid", rsp_valid, 0);
    check_val("rst_rdata", rsp_rdata, 0);
    check_val("rst_err", rsp_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic write/read, including the top word of the array.
    drive(1'b1, BASE,             32'h0BAD_F00D, 0, 0, a0);
    drive(1'b1, BASE + 32'h4,     32'hDEAD_BEEF, 0, 0, a0);
    drive(1'b0, BASE + 32'h4,     32'h0,         0, 0, a0);
    drive(1'b1, BASE + 32'h8,     32'hCAFE_0001, 0, 0, a0);
    drive(1'b1, BASE + 32'h3FC,   32'h55AA_33CC, 0, 0, a0);
    drive(1'b0, BASE + 32'h3FC,   32'h0,         0, 0, a0);

    // Out-of-range accesses on both sides leave the array untouched.
    drive(1'b0, BASE + 32'h400,   32'h0,         0, 0, a0);
    drive(1'b0, BASE,             32'h0,         0, 0, a0);
    drive(1'b0, BASE - 32'h4,     32'h0,         0, 0, a0);
    drive(1'b1, BASE + 32'h400,   32'hFFFF_FFFF, 0, 0, a0);
    drive(1'b0, BASE,             32'h0,         0, 0, a0);

    // Request held high across three reads.
    drive(1'b0, BASE,             32'h0, 1, 0, a0);
    drive(1'b0, BASE + 32'h4,     32'h0, 1, 0, a1);
    drive(1'b0, BASE + 32'h8,     32'h0, 0, 0, a2);
    check_val("b2b_gap1", a1 - a0, WAITC + 2);
    check_val("b2b_gap2", a2 - a1, WAITC + 2);
    wait_drain();

    // Reset while the write is waiting aborts it.
    drive(1'b1, BASE + 32'h8, 32'h1234_5678, 0, 1, a0);
    rst = 1'b1;
    #1;
    check_val("abort_ready", req_ready, 1);
    check_val("abort_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(1'b0, BASE + 32'h8, 32'h0, 0, 0, a0);

    // Misaligned write; the model decides whether index 1 changes.
    drive(1'b1, BASE + 32'h6, 32'h5A5A_5A5A, 0, 0, a0);
    drive(1'b0, BASE + 32'h4, 32'h0,         0, 0, a0);
    wait_drain();

    repeat (2) @(negedge clk);
    check_val("hold_rdata", rsp_rdata, last_rdata);
    check_val("hold_valid", rsp_valid, 0);

    for (int i = 0; i < 24; i++) begin
      we   = logic'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 3));
      addr = (sel == 3) ? BASE + 32'h400 + 32'(4 * $urandom_range(0, 15)) : BASE + 32'(4 * sel);
      keep = (i < 23) ? bit'($urandom_range(0, 1)) : 1'b0;
      drive(we, addr, $urandom, keep, 0, a0);
    end
    wait_drain();

    // Zero wait states: response on the cycle after acceptance.
    r0_valid = 1'b1; r0_we = 1'b1; r0_addr = BASE + 32'hC; r0_wdata = 32'h0F0F_1234;
    @(negedge clk);
    r0_valid = 1'b0;
    check_val("w0_wr_valid", r0_rsp_valid, 1);
    check_val("w0_wr_err", r0_rsp_err, 0);
    check_val("w0_wr_ready", r0_ready, 0);
    @(negedge clk);
    check_val("w0_idle_valid", r0_rsp_valid, 0);
    r0_valid = 1'b1; r0_we = 1'b0;
    @(negedge clk);
    r0_valid = 1'b0;
    check_val("w0_rd_valid", r0_rsp_valid, 1);
    check_val("w0_rd_rdata", r0_rsp_rdata, 32'h0F0F_1234);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
